pll_reset_sequencer: RTL and testbench

//  Sits between the board reference clock, the system PLL (75 MHz) and the SHA core

---
 rtl/pll_reset_sequencer.sv | 173 +++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock qualification and staggered per-core reset release.
// Runs on the free-running reference clock so it keeps sequencing while the PLL
// is unlocked. pll_locked is asynchronous and only used after a 2-flop synchroniser.
module pll_reset_sequencer #(
   parameter int NUM_CORES      = 10,
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 50000,
   parameter int STABLE_CYCLES  = 1024,
   parameter int STAGGER_CYCLES = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pll_locked,
   input  logic                 soft_rst_req,
   output logic                 pll_rst,
   output logic [NUM_CORES-1:0] core_rst_n,
   output logic                 ready,
   output logic [7:0]           lock_lost_cnt,
   output logic [7:0]           timeout_cnt
);

   localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CD  = (STABLE_CYCLES > STAGGER_CYCLES) ? STABLE_CYCLES : STAGGER_CYCLES;
   localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;

   typedef enum logic [2:0] {
      S_PLL_RST,
      S_WAIT_LOCK,
      S_STABLE,
      S_RELEASE,
      S_RUN
   } state_t;

   state_t               r_state, w_state;
   logic [CNT_W-1:0]     r_cnt, w_cnt;
   logic [1:0]           r_sync;
   logic                 r_pll_rst, w_pll_rst;
   logic [NUM_CORES-1:0] r_core_rst_n, w_core_rst_n;
   logic                 r_ready, w_ready;
   logic [7:0]           r_lost_cnt, w_lost_cnt;
   logic [7:0]           r_tmo_cnt, w_tmo_cnt;

   logic                 w_locked_s;
   logic                 w_cnt_last;
   logic [NUM_CORES:0]   w_core_shift;

   assign w_locked_s   = r_sync[1];
   // The counter holds the number of qualifying cycles still to go, so 1 (or 0) is the last one.
   assign w_cnt_last   = (r_cnt <= CNT_W'(1));
   assign w_core_shift = {r_core_rst_n, 1'b1};

   assign pll_rst       = r_pll_rst;
   assign core_rst_n    = r_core_rst_n;
   assign ready         = r_ready;
   assign lock_lost_cnt = r_lost_cnt;
   assign timeout_cnt   = r_tmo_cnt;

   // State, counter, synchroniser and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_PLL_RST;
         r_cnt        <= CNT_W'(PLL_RST_CYCLES);
         r_sync       <= '0;
         r_pll_rst    <= 1'b1;
         r_core_rst_n <= '0;
         r_ready      <= 1'b0;
         r_lost_cnt   <= '0;
         r_tmo_cnt    <= '0;
      end else begin
         r_state      <= w_state;
         r_cnt        <= w_cnt;
         r_sync       <= {r_sync[0], pll_locked};
         r_pll_rst    <= w_pll_rst;
         r_core_rst_n <= w_core_rst_n;
         r_ready      <= w_ready;
         r_lost_cnt   <= w_lost_cnt;
         r_tmo_cnt    <= w_tmo_cnt;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      w_state      = r_state;
      w_cnt        = r_cnt;
      w_pll_rst    = r_pll_rst;
      w_core_rst_n = r_core_rst_n;
      w_ready      = r_ready;
      w_lost_cnt   = r_lost_cnt;
      w_tmo_cnt    = r_tmo_cnt;

      case (r_state)
         S_PLL_RST: begin
            if (w_cnt_last) begin
               w_pll_rst = 1'b0;
               w_state   = S_WAIT_LOCK;
               w_cnt     = CNT_W'(LOCK_TIMEOUT);
            end else begin
               w_cnt = r_cnt - CNT_W'(1);
            end
         end

         S_WAIT_LOCK: begin
            if (w_locked_s) begin
               // The cycle that first sees lock already counts towards stability.
               if (STABLE_CYCLES == 1) begin
                  w_state      = S_RELEASE;
                  w_core_rst_n = NUM_CORES'(1);
                  w_cnt        = CNT_W'(STAGGER_CYCLES);
               end else begin
                  w_state = S_STABLE;
                  w_cnt   = CNT_W'(STABLE_CYCLES - 1);
               end
            end else if (w_cnt_last) begin
               w_tmo_cnt = (r_tmo_cnt == 8'hFF) ? r_tmo_cnt : r_tmo_cnt + 8'd1;
               w_pll_rst = 1'b1;
               w_state   = S_PLL_RST;
               w_cnt     = CNT_W'(PLL_RST_CYCLES);
            end else begin
               w_cnt = r_cnt - CNT_W'(1);
            end
         end

         S_STABLE: begin
            if (!w_locked_s) begin
               w_state = S_WAIT_LOCK;
               w_cnt   = CNT_W'(LOCK_TIMEOUT);
            end else if (w_cnt_last) begin
               w_state      = S_RELEASE;
               w_core_rst_n = NUM_CORES'(1);
               w_cnt        = CNT_W'(STAGGER_CYCLES);
            end else begin
               w_cnt = r_cnt - CNT_W'(1);
            end
         end

         S_RELEASE, S_RUN: begin
            if (!w_locked_s) begin
               w_core_rst_n = '0;
               w_ready      = 1'b0;
               w_pll_rst    = 1'b1;
               w_lost_cnt   = (r_lost_cnt == 8'hFF) ? r_lost_cnt : r_lost_cnt + 8'd1;
               w_state      = S_PLL_RST;
               w_cnt        = CNT_W'(PLL_RST_CYCLES);
            end else if (soft_rst_req) begin
               w_core_rst_n = '0;
               w_ready      = 1'b0;
               w_state      = S_STABLE;
               w_cnt        = CNT_W'(STABLE_CYCLES);
            end else if (r_state == S_RELEASE) begin
               if (w_cnt_last) begin
                  if (&r_core_rst_n) begin
                     w_state = S_RUN;
                     w_ready = 1'b1;
                  end else begin
                     w_core_rst_n = w_core_shift[NUM_CORES-1:0];
                     w_cnt        = CNT_W'(STAGGER_CYCLES);
                  end
               end else begin
                  w_cnt = r_cnt - CNT_W'(1);
               end
            end
         end

         default: begin
            w_state   = S_PLL_RST;
            w_pll_rst = 1'b1;
            w_cnt     = CNT_W'(PLL_RST_CYCLES);
         end
      endcase
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: stimulus pushes the hand-computed cycle and value of every
// expected output change; the monitor pops one entry per observed change.
module tb_pll_reset_sequencer;

   logic       clk;
   logic       rst_n;
   logic       pll_locked;
   logic       soft_rst_req;
   logic       pll_rst;
   logic [9:0] core_rst_n;
   logic       ready;
   logic [7:0] lock_lost_cnt;
   logic [7:0] timeout_cnt;

   pll_reset_sequencer #(
      .NUM_CORES      (10),
      .PLL_RST_CYCLES (4),
      .LOCK_TIMEOUT   (100),
      .STABLE_CYCLES  (8),
      .STAGGER_CYCLES (3)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pll_locked    (pll_locked),
      .soft_rst_req  (soft_rst_req),
      .pll_rst       (pll_rst),
      .core_rst_n    (core_rst_n),
      .ready         (ready),
      .lock_lost_cnt (lock_lost_cnt),
      .timeout_cnt   (timeout_cnt)
   );

   typedef struct {
      int          cyc;
      logic [27:0] val;
   } ev_t;

   ev_t         q[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   bit          done = 0;

   // expected output model, packed as {pll_rst, core_rst_n, ready, lost, timeout}
   logic        e_prst;
   logic [9:0]  e_core;
   logic        e_rdy;
   logic [7:0]  e_lost;
   logic [7:0]  e_tmo;
   logic [27:0] last_pushed;
   bit          pushed_any = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic at_cycle(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic expect_at(input int c);
      logic [27:0] v;
      v = {e_prst, e_core, e_rdy, e_lost, e_tmo};
      if (!pushed_any || v != last_pushed) begin
         q.push_back('{c, v});
         last_pushed = v;
         pushed_any  = 1;
      end
   endtask

   task automatic exp_release(input int c0, input int n, input bit with_ready);
      for (int i = 0; i < n; i++) begin
         e_core[i] = 1'b1;
         expect_at(c0 + 3 * i);
      end
      if (with_ready) begin
         e_rdy = 1'b1;
         expect_at(c0 + 30);
      end
   endtask

   task automatic do_reset(output int r);
      int c;
      c      = cyc;
      rst_n  = 1'b0;
      e_prst = 1'b1;
      e_core = '0;
      e_rdy  = 1'b0;
      e_lost = '0;
      e_tmo  = '0;
      expect_at(c + 1);
      at_cycle(c + 2);
      rst_n = 1'b1;
      r     = c + 2;
   endtask

   // Monitor: every change of the output bundle must match the next scoreboard entry.
   initial begin
      logic [27:0] snap;
      logic [27:0] prev;
      bit          have_prev;
      ev_t         e;
      have_prev = 0;
      prev      = '0;
      while (!done) begin
         @(posedge clk);
         #1;
         snap = {pll_rst, core_rst_n, ready, lock_lost_cnt, timeout_cnt};
         if (!have_prev || snap != prev) begin
            have_prev = 1;
            prev      = snap;
            n_checks++;
            if (q.size() == 0) begin
               $display("FAIL unexpected_change: actual cyc=%0d val=%h, required no change", cyc, snap);
            end else begin
               e = q.pop_front();
               if (e.cyc == cyc && e.val == snap)
                  n_pass++;
               else
                  $display("FAIL output_event: actual cyc=%0d val=%h, required cyc=%0d val=%h",
                           cyc, snap, e.cyc, e.val);
            end
         end
      end
      n_checks++;
      if (q.size() == 0)
         n_pass++;
      else
         $display("FAIL missing_events: actual %0d pending, required 0 (next cyc=%0d val=%h)",
                  q.size(), q[0].cyc, q[0].val);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Stimulus: directed sequence with hand-computed expected change cycles.
   initial begin
      int r, r6, r2;
      rst_n        = 1'b0;
      pll_locked   = 1'b0;
      soft_rst_req = 1'b0;
      do_reset(r);

      // Nominal bring-up: lock seen at edge r+20, 2 sync + 8 stable, stagger 3.
      e_prst = 1'b0;
      expect_at(r + 4);
      exp_release(r + 29, 10, 1);
      at_cycle(r + 19);
      pll_locked = 1'b1;

      // Lock loss in RUN: outputs drop 3 edges later, PLL restarted for 4 cycles.
      at_cycle(r + 64);
      e_core = '0; e_rdy = 1'b0; e_prst = 1'b1; e_lost = 8'd1;
      expect_at(r + 67);
      e_prst = 1'b0;
      expect_at(r + 71);
      exp_release(r + 89, 10, 1);
      pll_locked = 1'b0;
      at_cycle(r + 79);
      pll_locked = 1'b1;

      // Soft reset in RUN: cores reset, PLL untouched, re-release after 8 cycles.
      at_cycle(r + 124);
      e_core = '0; e_rdy = 1'b0;
      expect_at(r + 125);
      exp_release(r + 133, 10, 1);
      soft_rst_req = 1'b1;
      at_cycle(r + 125);
      soft_rst_req = 1'b0;

      // Soft reset coinciding with synchronised lock loss: lock loss wins.
      e_core = '0; e_rdy = 1'b0; e_prst = 1'b1; e_lost = 8'd2;
      expect_at(r + 172);
      e_prst = 1'b0;
      expect_at(r + 176);
      at_cycle(r + 169);
      pll_locked = 1'b0;
      at_cycle(r + 171);
      soft_rst_req = 1'b1;
      at_cycle(r + 172);
      soft_rst_req = 1'b0;

      // Unstable lock: 5 high, 1 low, then high; release only after 8 clean cycles.
      exp_release(r + 195, 5, 0);
      at_cycle(r + 179);
      pll_locked = 1'b1;
      at_cycle(r + 184);
      pll_locked = 1'b0;
      at_cycle(r + 185);
      pll_locked = 1'b1;

      // rst_n mid-release with cores 0..4 out of reset.
      at_cycle(r + 208);
      do_reset(r6);
      e_prst = 1'b0;
      expect_at(r6 + 4);
      exp_release(r6 + 12, 10, 1);
      at_cycle(r6 + 45);

      // Lock timeout: retries every 104 cycles, timeout_cnt saturates at 255.
      pll_locked = 1'b0;
      do_reset(r2);
      e_prst = 1'b0;
      expect_at(r2 + 4);
      for (int n = 1; n <= 258; n++) begin
         e_prst = 1'b1;
         e_tmo  = (n > 255) ? 8'd255 : 8'(n);
         expect_at(r2 + 4 + 104 * (n - 1) + 100);
         e_prst = 1'b0;
         expect_at(r2 + 4 + 104 * n);
      end
      at_cycle(r2 + 4 + 104 * 258 + 10);
      done = 1;
   end

endmodule
